legv8_control_sequencer: RTL
============================

Name: legv8_control_sequencer

Overview:
Multi-cycle control unit directly upstream of the 64-bit register/ALU/RAM datapath. It fetches a 32-bit LEGv8 instruction over a valid handshake and latches it in an instruction register (IR). It decodes the IR into the datapath's 31-bit control word and 64-bit constant K, and sequences FETCH/DECODE/EXECUTE/WRITEBACK. It consumes the datapath's 5-bit status bus for CBZ/CBNZ resolution.

Parameters:
INSTR_W, 32, instruction width
K_W, 64, constant/data width
CW_W, 31, control word width (fixed by datapath field layout)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
instr_valid  in  1  instruction memory presents a valid word on instr
instr  in  32  instruction word
fetch_req  out  1  high while waiting for an instruction
status  in  5  {V, C, N, Z(latched), Z(live)}; bit0 = live zero of current ALU result
controlWord  out  31  {PS[30:29], DA[28:24], SA[23:19], SB[18:14], FS[13:9], regW[8], ramW[7], EN_MEM[6], EN_ALU[5], EN_B[4], EN_PC[3], selB[2], PCsel[1], SL[0]}
K  out  64  immediate/offset to datapath
illegal  out  1  sticky: unsupported opcode decoded
state_dbg  out  2  current FSM state

Behaviour:
- Reset (reset==0 at a clock edge): state<=FETCH, IR<=0, illegal<=0. While reset==0, controlWord and K are forced to 0 combinationally, so no register/RAM write and PS=00 on that edge. fetch_req=0 while reset==0.
- PS encoding: 00 hold, 01 PC+4, 10 PC<=PCin (absolute), 11 PC<=PC+(PCin<<2) (relative).
- FS values: AND 00000, OR 00100, ADD 01000, SUB 01001, XOR 01100, LSR 10000, LSL 10100, PASSB 11000.
- States: FETCH(0), DECODE(1), EXECUTE(2), WRITEBACK(3), plus terminal HALT (state_dbg=3 with illegal=1).
- FETCH: fetch_req=1, controlWord=0. On instr_valid: IR<=instr, go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle, controlWord=0. Unknown opcode -> HALT with illegal<=1. HALT holds controlWord=0 until reset.
- EXECUTE, one cycle, PS=01 unless stated:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000, ADDS 10101011000, SUBS 11101011000): DA=Rd, SA=Rn, SB=Rm, selB=0, EN_ALU=1, regW=1. SL=1 only for ADDS/SUBS.
  - LSL 11010011011 / LSR 11010011010: selB=1, K=zero-extended shamt.
  - I-type (ADDI 1001000100, SUBI 1101000100): selB=1, K=zero-extended imm12.
  - STUR 11111000000: FS=ADD, selB=1, K=sign-extended imm9, SB=Rt, ramW=1, no regW.
  - LDUR 11111000010: ALU address as STUR, PS=00, no writes; next state WRITEBACK.
  - B 000101: PS=11, PCsel=1, K=sign-extended imm26.
  - BR 11010110000: PS=10, PCsel=0, SA=Rn.
  - CBZ 10110100 / CBNZ 10110101: SB=Rt, selB=0, FS=PASSB, PCsel=1, K=sign-extended imm19. PS is combinational from status[0]: 11 if branch taken, else 01.
  - After EXECUTE (except LDUR), next state is FETCH.
- WRITEBACK (LDUR only): same address controls, EN_MEM=1, regW=1, DA=Rt, PS=01; next state FETCH.
- At most one EN_* is high in any cycle. regW=1 implies exactly one EN_* is high.
- Register 31 (XZR) gets no special handling; it is the datapath's concern.
- instr_valid outside FETCH is ignored.

Decomposition:
- Package legv8_ctrl_pkg: opcode constants, FS codes, PS codes, control word bit positions, state enum.
- One sub-module, legv8_imm_gen: combinational IR -> K sign/zero extension by format.

Test Plan:
- Reset low 3 cycles with instr_valid=1 -> controlWord=0, fetch_req=0. After release: fetch_req=1, state_dbg=0.
- ADD X3,X1,X2 (0x8B020023) -> EXECUTE controlWord has DA=3, SA=1, SB=2, FS=01000, regW=1, EN_ALU=1, PS=01. Total 3 cycles from valid.
- LDUR X5,[X4,#-8] -> K=0xFFFFFFFFFFFFFFF8. EXECUTE cycle PS=00, regW=0. WRITEBACK cycle EN_MEM=1, regW=1, DA=5.
- CBZ X7,#4 with status[0]=1 -> PS=11, K=4. With status[0]=0 -> PS=01.
- Opcode 0xFFFFFFFF -> illegal=1, controlWord stays 0 and fetch_req stays 0 until reset.
- Reset asserted during EXECUTE of STUR -> ramW=0 on that edge; next cycle state FETCH.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control sequencer:
// opcode patterns, ALU function and PC-select codes, the control word
// field layout, FSM states and a one-hot-free opcode classifier.
package legv8_ctrl_pkg;

  // 11-bit opcodes (IR[31:21])
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_BR   = 11'b11010110000;
  // 10-bit opcodes (IR[31:22])
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  // 8-bit opcodes (IR[31:24])
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  // 6-bit opcode (IR[31:26])
  localparam logic [5:0]  OPC_B    = 6'b000101;

  // ALU function select
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_OR    = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_XOR   = 5'b01100;
  localparam logic [4:0] FS_LSR   = 5'b10000;
  localparam logic [4:0] FS_LSL   = 5'b10100;
  localparam logic [4:0] FS_PASSB = 5'b11000;

  // Program counter update select
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_ABS  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  // Control word, MSB first: PS[30:29] DA[28:24] SA[23:19] SB[18:14]
  // FS[13:9] regW[8] ramW[7] EN_MEM[6] EN_ALU[5] EN_B[4] EN_PC[3]
  // selB[2] PCsel[1] SL[0]
  typedef struct packed {
    logic [1:0] ps;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fs;
    logic       regw;
    logic       ramw;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic       selb;
    logic       pcsel;
    logic       sl;
  } cw_t;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS,
    OP_LSL, OP_LSR, OP_ADDI, OP_SUBI, OP_STUR, OP_LDUR,
    OP_B, OP_BR, OP_CBZ, OP_CBNZ, OP_ILLEGAL
  } op_e;

  // Longest opcode field wins; the shorter formats never alias an 11-bit one.
  function automatic op_e decode_op(input logic [31:0] ir);
    op_e op;
    op = OP_ILLEGAL;
    case (ir[31:21])
      OPC_ADD:  op = OP_ADD;
      OPC_SUB:  op = OP_SUB;
      OPC_AND:  op = OP_AND;
      OPC_ORR:  op = OP_ORR;
      OPC_EOR:  op = OP_EOR;
      OPC_ADDS: op = OP_ADDS;
      OPC_SUBS: op = OP_SUBS;
      OPC_LSL:  op = OP_LSL;
      OPC_LSR:  op = OP_LSR;
      OPC_STUR: op = OP_STUR;
      OPC_LDUR: op = OP_LDUR;
      OPC_BR:   op = OP_BR;
      default: begin
        if (ir[31:22] == OPC_ADDI)      op = OP_ADDI;
        else if (ir[31:22] == OPC_SUBI) op = OP_SUBI;
        else if (ir[31:24] == OPC_CBZ)  op = OP_CBZ;
        else if (ir[31:24] == OPC_CBNZ) op = OP_CBNZ;
        else if (ir[31:26] == OPC_B)    op = OP_B;
        else                            op = OP_ILLEGAL;
      end
    endcase
    return op;
  endfunction

  // ALU operation for the arithmetic/logic/shift group.
  function automatic logic [4:0] alu_fs(input op_e op);
    logic [4:0] fs;
    fs = FS_ADD;
    case (op)
      OP_AND:                  fs = FS_AND;
      OP_ORR:                  fs = FS_OR;
      OP_EOR:                  fs = FS_XOR;
      OP_SUB, OP_SUBS, OP_SUBI: fs = FS_SUB;
      OP_LSL:                  fs = FS_LSL;
      OP_LSR:                  fs = FS_LSR;
      default:                 fs = FS_ADD;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Immediate generator: picks the constant field out of the instruction
// register by format and extends it to the datapath width.
module legv8_imm_gen
  import legv8_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int K_W     = 64
) (
  input  logic [INSTR_W-1:0] i_ir,
  output logic [K_W-1:0]     o_k
);

  op_e w_op;

  assign w_op = decode_op(i_ir);

  // Shift amounts and imm12 are unsigned; memory and branch offsets are signed.
  always_comb begin
    o_k = '0;
    case (w_op)
      OP_LSL, OP_LSR:   o_k = {{(K_W-6){1'b0}}, i_ir[15:10]};
      OP_ADDI, OP_SUBI: o_k = {{(K_W-12){1'b0}}, i_ir[21:10]};
      OP_STUR, OP_LDUR: o_k = {{(K_W-9){i_ir[20]}}, i_ir[20:12]};
      OP_B:             o_k = {{(K_W-26){i_ir[25]}}, i_ir[25:0]};
      OP_CBZ, OP_CBNZ:  o_k = {{(K_W-19){i_ir[23]}}, i_ir[23:5]};
      default:          o_k = '0;
    endcase
  end

endmodule

// File: rtl/legv8_control_sequencer.sv
// Multi-cycle LEGv8 control unit: fetches an instruction into IR, decodes
// it, and drives the datapath control word and constant K through
// FETCH / DECODE / EXECUTE / WRITEBACK. Unknown opcodes halt the sequencer
// with a sticky illegal flag until reset.
module legv8_control_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int K_W     = 64,
  parameter int CW_W    = 31
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               fetch_req,
  input  logic [4:0]         status,
  output logic [CW_W-1:0]    controlWord,
  output logic [K_W-1:0]     K,
  output logic               illegal,
  output logic [1:0]         state_dbg
);

  state_e             r_state;
  state_e             w_next;
  logic [INSTR_W-1:0] r_ir;
  logic               r_illegal;

  op_e                w_op;
  cw_t                w_cw;
  logic               w_fetch;
  logic               w_k_en;
  logic               w_taken;
  logic [K_W-1:0]     w_imm;
  logic [4:0]         w_rd;
  logic [4:0]         w_rn;
  logic [4:0]         w_rm;
  logic               w_status_unused;

  assign w_op  = decode_op(r_ir);
  assign w_rd  = r_ir[4:0];
  assign w_rn  = r_ir[9:5];
  assign w_rm  = r_ir[20:16];

  // Only the live zero flag steers CBZ/CBNZ; the other flags are not needed here.
  assign w_status_unused = ^status[4:1];
  assign w_taken = (w_op == OP_CBZ) ? status[0] : ~status[0];

  legv8_imm_gen #(
    .INSTR_W (INSTR_W),
    .K_W     (K_W)
  ) u_imm_gen (
    .i_ir (r_ir),
    .o_k  (w_imm)
  );

  // State, instruction register and sticky illegal flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && instr_valid) begin
        r_ir <= instr;
      end
      if (r_state == S_DECODE && w_op == OP_ILLEGAL) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state and per-state control word; every field defaults to zero.
  always_comb begin
    w_next  = r_state;
    w_cw    = '0;
    w_fetch = 1'b0;
    w_k_en  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_fetch = 1'b1;
        if (instr_valid) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = (w_op == OP_ILLEGAL) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        w_k_en = 1'b1;
        w_next = (w_op == OP_LDUR) ? S_WRITEBACK : S_FETCH;
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS,
          OP_LSL, OP_LSR, OP_ADDI, OP_SUBI: begin
            w_cw.ps     = PS_INC;
            w_cw.da     = w_rd;
            w_cw.sa     = w_rn;
            w_cw.sb     = (w_op == OP_ADDI || w_op == OP_SUBI) ? 5'd0 : w_rm;
            w_cw.fs     = alu_fs(w_op);
            w_cw.selb   = (w_op == OP_LSL || w_op == OP_LSR ||
                           w_op == OP_ADDI || w_op == OP_SUBI);
            w_cw.sl     = (w_op == OP_ADDS || w_op == OP_SUBS);
            w_cw.en_alu = 1'b1;
            w_cw.regw   = 1'b1;
          end
          OP_STUR: begin
            // Address = Rn + imm9 through the ALU; store data comes from Rt on B.
            w_cw.ps   = PS_INC;
            w_cw.sa   = w_rn;
            w_cw.sb   = w_rd;
            w_cw.fs   = FS_ADD;
            w_cw.selb = 1'b1;
            w_cw.ramw = 1'b1;
          end
          OP_LDUR: begin
            // Address phase only; PC holds until the load is written back.
            w_cw.ps   = PS_HOLD;
            w_cw.sa   = w_rn;
            w_cw.fs   = FS_ADD;
            w_cw.selb = 1'b1;
          end
          OP_B: begin
            w_cw.ps    = PS_REL;
            w_cw.pcsel = 1'b1;
          end
          OP_BR: begin
            w_cw.ps = PS_ABS;
            w_cw.sa = w_rn;
          end
          OP_CBZ, OP_CBNZ: begin
            w_cw.ps    = w_taken ? PS_REL : PS_INC;
            w_cw.sb    = w_rd;
            w_cw.fs    = FS_PASSB;
            w_cw.pcsel = 1'b1;
          end
          default: w_cw = '0;
        endcase
      end
      S_WRITEBACK: begin
        // Same address controls as the LDUR execute cycle, now committing the load.
        w_k_en      = 1'b1;
        w_next      = S_FETCH;
        w_cw.ps     = PS_INC;
        w_cw.da     = w_rd;
        w_cw.sa     = w_rn;
        w_cw.fs     = FS_ADD;
        w_cw.selb   = 1'b1;
        w_cw.en_mem = 1'b1;
        w_cw.regw   = 1'b1;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // While reset is low nothing may be written and the PC must hold.
  assign controlWord = reset ? w_cw : '0;
  assign K           = (reset && w_k_en) ? w_imm : '0;
  assign fetch_req   = reset & w_fetch;
  assign illegal     = r_illegal;
  assign state_dbg   = (r_state == S_HALT) ? 2'd3 : r_state[1:0];

endmodule
